// File: rtl/othello_move_ctrl.sv
// Per-turn Othello move controller: key edges -> cursor/side, board detect/write strobes, legality, passes, game end.
// Optional CURSOR_WRAP_EN: cursor wraps modulo 8 instead of saturating at 0/7.
module othello_move_ctrl #(
  parameter int DET_WAIT = 8,
  parameter int WR_WAIT  = 8
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       key_up,
  input  logic       key_down,
  input  logic       key_left,
  input  logic       key_right,
  input  logic       key_place,
  input  logic       key_pass,
  input  logic [1:0] q,
  input  logic [7:0] dir,
  output logic [2:0] x,
  output logic [2:0] y,
  output logic       side,
  output logic       detecten,
  output logic       writeen,
  output logic       busy,
  output logic       illegal,
  output logic [5:0] move_count,
  output logic       game_over
);

  localparam int MAXW = (DET_WAIT > WR_WAIT) ? DET_WAIT : WR_WAIT;
  localparam int CW   = $clog2(MAXW) + 1;

  typedef enum logic [3:0] {
    S_IDLE, S_DETECT, S_DWAIT, S_CHECK, S_WRITE, S_WWAIT, S_TOGGLE, S_REJECT, S_PASS
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [5:0]    r_prev, w_keys, w_press;
  logic [CW-1:0] r_cnt;
  logic [1:0]    r_pass_streak;
  logic [2:0]    r_x, r_y, w_x_nxt, w_y_nxt;
  logic          r_side, r_game_over;
  logic [5:0]    r_move_count;
  logic          w_act, w_cur;
  logic          w_unused_q0;

  assign w_unused_q0 = q[0];

  // bit order encodes priority: place > pass > up > down > left > right
  assign w_keys  = {key_place, key_pass, key_up, key_down, key_left, key_right};
  assign w_press = w_keys & ~r_prev;
  assign w_act   = (r_state == S_IDLE) && !r_game_over;
  assign w_cur   = w_act && !w_press[5] && !w_press[4] && (|w_press[3:0]);

  always_ff @(posedge clock) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_act) begin
          if (w_press[5])      w_state_nxt = q[1] ? S_REJECT : S_DETECT;
          else if (w_press[4]) w_state_nxt = S_PASS;
        end
      end
      S_DETECT: w_state_nxt = S_DWAIT;
      S_DWAIT:  if (r_cnt == '0) w_state_nxt = S_CHECK;
      S_CHECK:  w_state_nxt = (dir != 8'd0) ? S_WRITE : S_REJECT;
      S_WRITE:  w_state_nxt = S_WWAIT;
      S_WWAIT:  if (r_cnt == '0) w_state_nxt = S_TOGGLE;
      S_TOGGLE: w_state_nxt = S_IDLE;
      S_REJECT: w_state_nxt = S_IDLE;
      S_PASS:   w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_x_nxt = r_x;
    w_y_nxt = r_y;
`ifdef CURSOR_WRAP_EN
    if (w_press[3])      w_y_nxt = r_y - 3'd1;
    else if (w_press[2]) w_y_nxt = r_y + 3'd1;
    else if (w_press[1]) w_x_nxt = r_x - 3'd1;
    else if (w_press[0]) w_x_nxt = r_x + 3'd1;
`else
    // an edge press is consumed but leaves the coordinate alone
    if (w_press[3])      begin if (r_y != 3'd0) w_y_nxt = r_y - 3'd1; end
    else if (w_press[2]) begin if (r_y != 3'd7) w_y_nxt = r_y + 3'd1; end
    else if (w_press[1]) begin if (r_x != 3'd0) w_x_nxt = r_x - 3'd1; end
    else if (w_press[0]) begin if (r_x != 3'd7) w_x_nxt = r_x + 3'd1; end
`endif
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_prev        <= '0;
      r_cnt         <= '0;
      r_pass_streak <= '0;
      r_x           <= '0;
      r_y           <= '0;
      r_side        <= 1'b0;
      r_move_count  <= '0;
      r_game_over   <= 1'b0;
    end else begin
      // sampled every cycle so keys held through a busy turn never fire later
      r_prev <= w_keys;
      if (w_cur) begin
        r_x           <= w_x_nxt;
        r_y           <= w_y_nxt;
        r_pass_streak <= '0;
      end
      case (r_state)
        S_DETECT: r_cnt <= CW'(DET_WAIT - 1);
        S_WRITE:  r_cnt <= CW'(WR_WAIT - 1);
        S_DWAIT, S_WWAIT: if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
        S_TOGGLE: begin
          r_side        <= ~r_side;
          r_pass_streak <= '0;
          if (r_move_count != 6'd60) r_move_count <= r_move_count + 6'd1;
          if (r_move_count >= 6'd59) r_game_over  <= 1'b1;
        end
        S_PASS: begin
          r_side <= ~r_side;
          if (r_pass_streak != 2'd3) r_pass_streak <= r_pass_streak + 2'd1;
          if (r_pass_streak != 2'd0) r_game_over   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign x          = r_x;
  assign y          = r_y;
  assign side       = r_side;
  assign move_count = r_move_count;
  assign game_over  = r_game_over;
  assign detecten   = (r_state == S_DETECT);
  assign writeen    = (r_state == S_WRITE);
  assign illegal    = (r_state == S_REJECT);
  assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_othello_move_ctrl.sv
// Bench for othello_move_ctrl: scenario tasks plus random actions checked against a rule-level game model.
module tb_othello_move_ctrl;

  localparam int DW  = 8;
  localparam int WW  = 8;
  localparam int WIN = DW + WW + 6;

  localparam logic [5:0] K_PL = 6'b100000;
  localparam logic [5:0] K_PA = 6'b010000;
  localparam logic [5:0] K_UP = 6'b001000;
  localparam logic [5:0] K_DN = 6'b000100;
  localparam logic [5:0] K_LF = 6'b000010;
  localparam logic [5:0] K_RT = 6'b000001;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       key_up = 0, key_down = 0, key_left = 0, key_right = 0, key_place = 0, key_pass = 0;
  logic [1:0] q = '0;
  logic [7:0] dir = '0;
  logic [2:0] x, y;
  logic       side, detecten, writeen, busy, illegal, game_over;
  logic [5:0] move_count;

  othello_move_ctrl #(.DET_WAIT(DW), .WR_WAIT(WW)) dut (
    .clock(clock), .resetn(resetn),
    .key_up(key_up), .key_down(key_down), .key_left(key_left), .key_right(key_right),
    .key_place(key_place), .key_pass(key_pass), .q(q), .dir(dir),
    .x(x), .y(y), .side(side), .detecten(detecten), .writeen(writeen),
    .busy(busy), .illegal(illegal), .move_count(move_count), .game_over(game_over)
  );

  always #5 clock = ~clock;

  // cycle index (1 = cycle after the press) of first strobe, strobe counts, busy length, etc.
  typedef struct packed {
    int det_cyc; int det_cnt; int wr_cyc; int wr_cnt; int ill_cyc; int ill_cnt;
    int both; int busy_len; int side_cyc; int xy_cyc;
  } obs_t;

  int n_checks = 0;
  int n_fail   = 0;

  int m_x, m_y, m_side, m_mc, m_go, m_streak;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic int mv(input int v, input int d);
`ifdef CURSOR_WRAP_EN
    return (v + d + 8) % 8;
`else
    if (v + d < 0) return 0;
    if (v + d > 7) return 7;
    return v + d;
`endif
  endfunction

  function automatic logic [14:0] dut_st();
    return {x, y, side, move_count, game_over, busy};
  endfunction

  function automatic logic [14:0] mdl_st();
    return {3'(m_x), 3'(m_y), 1'(m_side), 6'(m_mc), 1'(m_go), 1'b0};
  endfunction

  task automatic model_reset();
    m_x = 0; m_y = 0; m_side = 0; m_mc = 0; m_go = 0; m_streak = 0;
  endtask

  // Game rules applied to one key action; returns the strobe timeline it should produce.
  task automatic model_step(input logic [5:0] k, input logic [1:0] qv, input logic [7:0] dv, output obs_t e);
    int nx, ny;
    e = '0;
    if (m_go != 0 || k == 6'd0) return;
    if (k[5]) begin
      if (qv[1]) begin
        e.ill_cyc = 1; e.ill_cnt = 1; e.busy_len = 1;
      end else begin
        e.det_cyc = 1; e.det_cnt = 1;
        if (dv != 8'd0) begin
          e.wr_cyc = 3 + DW; e.wr_cnt = 1; e.busy_len = 4 + DW + WW; e.side_cyc = 5 + DW + WW;
          m_side = 1 - m_side; m_streak = 0;
          m_mc = (m_mc + 1 > 60) ? 60 : m_mc + 1;
          if (m_mc == 60) m_go = 1;
        end else begin
          e.ill_cyc = 3 + DW; e.ill_cnt = 1; e.busy_len = 3 + DW;
        end
      end
    end else if (k[4]) begin
      e.busy_len = 1; e.side_cyc = 2;
      m_side = 1 - m_side; m_streak++;
      if (m_streak >= 2) m_go = 1;
    end else begin
      nx = m_x; ny = m_y;
      if (k[3])      ny = mv(m_y, -1);
      else if (k[2]) ny = mv(m_y, 1);
      else if (k[1]) nx = mv(m_x, -1);
      else           nx = mv(m_x, 1);
      if (nx != m_x || ny != m_y) e.xy_cyc = 1;
      m_x = nx; m_y = ny; m_streak = 0;
    end
  endtask

  // Press keys for one cycle, then watch the DUT for a fixed window; dir is valid only in its sample cycle.
  task automatic run_attempt(input logic [5:0] k, input logic [1:0] qv, input logic [7:0] dv, output obs_t o);
    logic [5:0] xy0;
    logic       s0;
    o = '0;
    xy0 = {x, y};
    s0 = side;
    {key_place, key_pass, key_up, key_down, key_left, key_right} = k;
    q = qv;
    dir = '0;
    tick();
    for (int c = 1; c <= WIN; c++) begin
      {key_place, key_pass, key_up, key_down, key_left, key_right} = '0;
      dir = (c == 2 + DW) ? dv : 8'd0;
      if (detecten) begin if (o.det_cyc == 0) o.det_cyc = c; o.det_cnt = o.det_cnt + 1; end
      if (writeen)  begin if (o.wr_cyc == 0)  o.wr_cyc = c;  o.wr_cnt = o.wr_cnt + 1;  end
      if (illegal)  begin if (o.ill_cyc == 0) o.ill_cyc = c; o.ill_cnt = o.ill_cnt + 1; end
      if (detecten && writeen) o.both = o.both + 1;
      if (busy) o.busy_len = o.busy_len + 1;
      if (side != s0 && o.side_cyc == 0) o.side_cyc = c;
      if ({x, y} != xy0 && o.xy_cyc == 0) o.xy_cyc = c;
      tick();
    end
    dir = '0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    tick();
    n_checks++;
    if ({x, y, side, detecten, writeen, busy, illegal, move_count, game_over} !== 19'd0) begin
      n_fail++;
      $display("FAIL reset_values got=%h want=0", {x, y, side, detecten, writeen, busy, illegal, move_count, game_over});
    end
    resetn = 1'b1;
    model_reset();
    tick();
  endtask

  task automatic test_cursor();
    logic [5:0] seq [5] = '{K_RT, K_RT, K_RT, K_DN, K_DN};
    obs_t o, e;
    foreach (seq[i]) begin
      model_step(seq[i], 2'b00, 8'h00, e);
      run_attempt(seq[i], 2'b00, 8'h00, o);
      n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL cursor_obs[%0d] got=%h want=%h", i, o, e); end
    end
    n_checks++;
    if (dut_st() !== {3'd3, 3'd2, 1'b0, 6'd0, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL cursor_state got=%h want=%h", dut_st(), {3'd3, 3'd2, 1'b0, 6'd0, 1'b0, 1'b0});
    end
  endtask

  task automatic test_place();
    // legal, occupied cell, no legal direction
    logic [1:0] qs [3] = '{2'b00, 2'b10, 2'b00};
    logic [7:0] ds [3] = '{8'h10, 8'h10, 8'h00};
    obs_t o, e;
    foreach (qs[i]) begin
      model_step(K_PL, qs[i], ds[i], e);
      run_attempt(K_PL, qs[i], ds[i], o);
      n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL place_obs[%0d] got=%h want=%h", i, o, e); end
      n_checks++;
      if (dut_st() !== mdl_st()) begin n_fail++; $display("FAIL place_state[%0d] got=%h want=%h", i, dut_st(), mdl_st()); end
    end
  endtask

  task automatic test_priority_edges();
    obs_t o, e;
    // place together with up: only placement happens
    model_step(K_PL | K_UP, 2'b00, 8'h01, e);
    run_attempt(K_PL | K_UP, 2'b00, 8'h01, o);
    n_checks++;
    if (o !== e) begin n_fail++; $display("FAIL prio_obs got=%h want=%h", o, e); end
    n_checks++;
    if (dut_st() !== mdl_st()) begin n_fail++; $display("FAIL prio_state got=%h want=%h", dut_st(), mdl_st()); end
    // drive x up to 7, then one more right; y to 0, then one more up
    for (int i = 0; i < 5; i++) begin model_step(K_RT, 2'b00, 8'h00, e); run_attempt(K_RT, 2'b00, 8'h00, o); end
    for (int i = 0; i < 2; i++) begin model_step(K_UP, 2'b00, 8'h00, e); run_attempt(K_UP, 2'b00, 8'h00, o); end
    n_checks++;
    if ({x, y} !== 6'o70) begin n_fail++; $display("FAIL edge_setup got=%h want=%h", {x, y}, 6'o70); end
    model_step(K_RT, 2'b00, 8'h00, e);
    run_attempt(K_RT, 2'b00, 8'h00, o);
    n_checks++;
    if (o !== e || dut_st() !== mdl_st()) begin
      n_fail++; $display("FAIL edge_right got=%h/%h want=%h/%h", o, dut_st(), e, mdl_st());
    end
    model_step(K_UP, 2'b00, 8'h00, e);
    run_attempt(K_UP, 2'b00, 8'h00, o);
    n_checks++;
    if (o !== e || dut_st() !== mdl_st()) begin
      n_fail++; $display("FAIL edge_up got=%h/%h want=%h/%h", o, dut_st(), e, mdl_st());
    end
  endtask

  task automatic test_pass_gameover();
    logic [5:0] seq [6] = '{K_PA, K_LF, K_PA, K_PA, K_RT, K_PL};
    obs_t o, e;
    foreach (seq[i]) begin
      model_step(seq[i], 2'b00, 8'h22, e);
      run_attempt(seq[i], 2'b00, 8'h22, o);
      n_checks++;
      if (o !== e || dut_st() !== mdl_st()) begin
        n_fail++; $display("FAIL pass_seq[%0d] got=%h/%h want=%h/%h", i, o, dut_st(), e, mdl_st());
      end
    end
    n_checks++;
    if (game_over !== 1'b1) begin n_fail++; $display("FAIL pass_gameover got=%b want=1", game_over); end
    test_reset();
  endtask

  task automatic test_reset_mid();
    int strobes = 0;
    {key_place, q} = {1'b1, 2'b00};
    tick();
    key_place = 1'b0;
    for (int c = 0; c < 5; c++) tick();
    resetn = 1'b0;
    tick();
    n_checks++;
    if ({x, y, side, detecten, writeen, busy, illegal, move_count, game_over} !== 19'd0) begin
      n_fail++;
      $display("FAIL reset_mid got=%h want=0", {x, y, side, detecten, writeen, busy, illegal, move_count, game_over});
    end
    resetn = 1'b1;
    model_reset();
    for (int c = 0; c < WIN; c++) begin
      dir = 8'hff;
      if (detecten || writeen || illegal) strobes++;
      tick();
    end
    dir = '0;
    n_checks++;
    if (strobes != 0) begin n_fail++; $display("FAIL reset_mid_strobes got=%0d want=0", strobes); end
  endtask

  task automatic test_saturate60();
    obs_t o, e;
    int bad = 0;
    for (int i = 0; i < 61; i++) begin
      model_step(K_PL, 2'b00, 8'h80, e);
      run_attempt(K_PL, 2'b00, 8'h80, o);
      if (o !== e || dut_st() !== mdl_st()) bad++;
    end
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL sat60_seq got=%0d bad moves want=0", bad); end
    n_checks++;
    if ({move_count, game_over} !== {6'd60, 1'b1}) begin
      n_fail++; $display("FAIL sat60_final got=%0d/%b want=60/1", move_count, game_over);
    end
    test_reset();
  endtask

  task automatic test_random();
    obs_t o, e;
    logic [5:0] k;
    logic [1:0] qv;
    logic [7:0] dv;
    for (int i = 0; i < 50; i++) begin
      case ($urandom_range(0, 9))
        0, 1:    k = K_PL;
        2:       k = K_PA;
        3:       k = 6'($urandom_range(0, 63));
        4:       k = K_PL | 6'($urandom_range(0, 31));
        default: k = 6'b1 << $urandom_range(0, 3);
      endcase
      qv = 2'($urandom_range(0, 3));
      dv = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      model_step(k, qv, dv, e);
      run_attempt(k, qv, dv, o);
      n_checks++;
      if (o !== e || dut_st() !== mdl_st()) begin
        n_fail++; $display("FAIL random[%0d] k=%b q=%b dir=%h got=%h/%h want=%h/%h", i, k, qv, dv, o, dut_st(), e, mdl_st());
      end
      if (m_go != 0) test_reset();
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_cursor();
    test_place();
    test_priority_edges();
    test_pass_gameover();
    test_reset_mid();
    test_saturate60();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
